// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the boot-time system ID checker.
// The optional read-stall timeout is enabled by defining SYSID_CHECKER_TIMEOUT_EN.
package sysid_checker_pkg;

  localparam int unsigned SYSID_DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StRdTs,
    StCheck,
    StFin
  } sysid_state_e;

endpackage

// File: rtl/sysid_checker_timer.sv
// Per-read stall counter; expired flags the stalled cycle on which the count reaches the limit.
// Only instantiated when SYSID_CHECKER_TIMEOUT_EN is defined.
module sysid_checker_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  logic [15:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (stall && (count_q != '1)) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Fires when this stalled cycle brings the count up to TIMEOUT_CYCLES.
  assign expired = stall && (({1'b0, count_q} + 17'd1) >= 17'(TIMEOUT_CYCLES));

endmodule

// File: rtl/sysid_checker.sv
// Reads the two-word system ID slave after boot and registers a pass/fail verdict.
// Define SYSID_CHECKER_TIMEOUT_EN to abort reads stalled for TIMEOUT_CYCLES cycles.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXP_ID         = 32'd1743703423,
  parameter logic [SYSID_DATA_W-1:0] EXP_TS         = 32'd1454361357,
  parameter int unsigned             TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    avm_address,
  output logic                    avm_read,
  input  logic                    avm_waitrequest,
  input  logic [SYSID_DATA_W-1:0] avm_readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    timeout,
  output logic [SYSID_DATA_W-1:0] id_word,
  output logic [SYSID_DATA_W-1:0] ts_word
);

  sysid_state_e state_q, state_d;
  logic pass_q, pass_d, id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
  logic [SYSID_DATA_W-1:0] id_word_q, id_word_d, ts_word_q, ts_word_d;
  logic expired;
  logic stall;

  assign stall = avm_read & avm_waitrequest;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  sysid_checker_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (~stall),
    .stall  (stall),
    .expired(expired)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign expired    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    timeout_d   = timeout_q;
    id_word_d   = id_word_q;
    ts_word_d   = ts_word_q;
    avm_read    = 1'b0;
    avm_address = SYSID_ADDR_ID;
    busy        = 1'b1;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          state_d   = StRdId;
          pass_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          id_word_d = '0;
          ts_word_d = '0;
        end
      end
      StRdId: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          id_word_d = avm_readdata;
          state_d   = StRdTs;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StFin;
        end
      end
      StRdTs: begin
        avm_read    = 1'b1;
        avm_address = SYSID_ADDR_TS;
        if (!avm_waitrequest) begin
          ts_word_d = avm_readdata;
          state_d   = StCheck;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StFin;
        end
      end
      StCheck: begin
        id_ok_d = (id_word_q == EXP_ID);
        ts_ok_d = (ts_word_q == EXP_TS);
        pass_d  = (id_word_q == EXP_ID) && (ts_word_q == EXP_TS);
        state_d = StFin;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pass_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      id_word_q <= '0;
      ts_word_q <= '0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
      id_word_q <= id_word_d;
      ts_word_q <= ts_word_d;
    end
  end

  assign pass    = pass_q;
  assign id_ok   = id_ok_q;
  assign ts_ok   = ts_ok_q;
  assign timeout = timeout_q;
  assign id_word = id_word_q;
  assign ts_word = ts_word_q;

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Boot-time controller that reads the two-word system ID slave over an Avalon-MM master port and compares it against expected values.
- Word 0 is the system ID; word 1 is the generation timestamp.
- Sits between the reset/boot sequencer and the system ID slave.
- Gates software start-up with a registered pass/fail verdict, so a mismatched FPGA image and software build is caught in hardware.

Parameters:
- EXP_ID, 32'd1743703423: expected system ID (read at address 0).
- EXP_TS, 32'd1454361357: expected timestamp (read at address 1).
- TIMEOUT_CYCLES, 255: maximum waitrequest stall per read; used only with the optional feature; legal range 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  1-cycle pulse; begins a check when idle
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  Avalon read strobe
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  slave read data, valid in the cycle avm_read=1 and avm_waitrequest=0
- busy  out  1  check in progress
- done  out  1  1-cycle pulse at end of check
- pass  out  1  sticky verdict: both words matched
- id_ok  out  1  sticky: ID word matched
- ts_ok  out  1  sticky: timestamp word matched
- timeout  out  1  sticky: read aborted by timeout (tied 0 without the feature)
- id_word  out  32  captured ID word
- ts_word  out  32  captured timestamp word

Behaviour:
- Reset: clk domain only. Reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, captured words 0.
- Reset mid-operation: abort immediately; avm_read drops asynchronously with reset; no done pulse is generated.
- States: IDLE, RD_ID, RD_TS, CHECK, FIN.
- IDLE: avm_read=0, busy=0. On start=1, go to RD_ID and clear pass/id_ok/ts_ok/timeout.
- RD_ID: avm_read=1, avm_address=0, busy=1.
  - Address and read are held stable while avm_waitrequest=1.
  - In the cycle avm_waitrequest=0, capture avm_readdata into id_word and go to RD_TS.
- RD_TS: same as RD_ID with avm_address=1; capture into ts_word, then go to CHECK.
- CHECK: id_ok <= (id_word==EXP_ID); ts_ok <= (ts_word==EXP_TS); pass <= both; go to FIN.
- FIN: done=1 for exactly one cycle; go to IDLE. Verdict outputs hold until the next accepted start.
- Latency with zero wait states: start sampled at edge 0; read ID during cycle 1; read TS during cycle 2; CHECK in cycle 3; done high in cycle 4. Total 4 cycles from start to done.
- Each wait-state cycle adds one cycle of latency.
- start while busy=1 (including in FIN): ignored; no queueing.
- start in the same cycle as reset deassertion: accepted only if sampled at a clock edge where reset=0.
- avm_read is never asserted in IDLE, CHECK or FIN. Exactly two read transfers occur per check.

Optional Feature:
- Macro: SYSID_CHECKER_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter clears on entry to each read state and increments each cycle avm_waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES with waitrequest still high: deassert avm_read the next cycle; set timeout=1, pass=0, id_ok=0, ts_ok=0; skip CHECK; go to FIN (done pulses).
  - Words not yet captured remain 0.
- Undefined:
  - No counter. The block waits indefinitely on waitrequest.
  - timeout is tied to 0 and TIMEOUT_CYCLES is unused.

Decomposition:
- Package sysid_checker_pkg contains:
  - the state enum type;
  - address constants SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - the data width constant 32.
- One sub-module, sysid_checker_timer: a stall counter with inputs clear and stall, and output expired. It is instantiated only under SYSID_CHECKER_TIMEOUT_EN.

Test Plan:
- Zero-wait slave returning 1743703423 / 1454361357, start pulse -> done at cycle 4; pass=1, id_ok=1, ts_ok=1; exactly 2 reads, to addresses 0 then 1.
- Slave returns ID 32'h0000_0001, correct TS -> id_ok=0, ts_ok=1, pass=0; id_word=1.
- waitrequest high 3 cycles on each read -> address/read held stable while stalled; done at cycle 10; data captured only on the waitrequest=0 cycle.
- start pulsed in cycles 2 and 4 of an active check -> ignored; single done pulse; no extra reads.
- reset asserted in RD_TS -> avm_read=0 immediately; all outputs 0; no done pulse; a following start runs a normal check.
- With SYSID_CHECKER_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high on the ID read -> timeout=1, pass=0, single done pulse, id_word=0.
